// File: rtl/hazard_stall_unit.sv
// ID-stage hazard unit: bubbles the decoded control bus on load-use or
// multi-cycle RAW/structural hazards, flushes IF/ID on taken branches.
module hazard_stall_unit #(
  parameter int REG_ADDR_W   = 5,
  parameter int CTRL_W       = 9,
  parameter int LOAD_LATENCY = 1,
  parameter int MUL_LATENCY  = 4,
  parameter int PERF_W       = 16
) (
  input  logic                  clk,
  input  logic                  arst,
  input  logic [CTRL_W-1:0]     ctrl_in,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs1,
  input  logic [REG_ADDR_W-1:0] IF_ID_rs2,
  input  logic                  rs1_used,
  input  logic                  rs2_used,
  input  logic [REG_ADDR_W-1:0] IF_ID_rd,
  input  logic                  mul_issue,
  input  logic                  memread_ID_EX,
  input  logic [REG_ADDR_W-1:0] ID_EX_rd,
  input  logic                  branch_taken,
  output logic [CTRL_W-1:0]     ctrl_out,
  output logic                  prevent_update_pc,
  output logic                  prevent_update_reg_IF_ID,
  output logic                  flush_IF_ID,
  output logic                  mul_busy,
  output logic [PERF_W-1:0]     stall_cycles
);

  localparam int LD_W  = (LOAD_LATENCY > 1) ? $clog2(LOAD_LATENCY) : 1;
  localparam int MUL_W = $clog2(MUL_LATENCY + 1);
  localparam logic [LD_W-1:0]  LD_INIT  = LD_W'(LOAD_LATENCY - 1);
  localparam logic [MUL_W-1:0] MUL_INIT = MUL_W'(MUL_LATENCY);

  logic [LD_W-1:0]       ld_cnt;
  logic [MUL_W-1:0]      mul_cnt;
  logic [REG_ADDR_W-1:0] mul_rd;
  logic [PERF_W-1:0]     perf_q;

  logic ld_match, mul_match, load_hz, mul_hz, stall, mul_accept;

  assign ld_match  = (rs1_used && (IF_ID_rs1 == ID_EX_rd)) ||
                     (rs2_used && (IF_ID_rs2 == ID_EX_rd));
  assign mul_match = (rs1_used && (IF_ID_rs1 == mul_rd)) ||
                     (rs2_used && (IF_ID_rs2 == mul_rd));

  // Only a fresh load is checked; once ld_cnt runs the stall is unconditional.
  assign load_hz    = (ld_cnt == '0) && memread_ID_EX && (ID_EX_rd != '0) && ld_match;
  assign mul_hz     = (mul_cnt != '0) && (mul_issue || ((mul_rd != '0) && mul_match));
  assign stall      = load_hz || (ld_cnt != '0) || mul_hz;
  assign mul_accept = mul_issue && !stall && !branch_taken;

  always_ff @(posedge clk or posedge arst) begin
    if (arst)                ld_cnt <= '0;
    else if (branch_taken)   ld_cnt <= '0;
    else if (load_hz)        ld_cnt <= LD_INIT;
    else if (ld_cnt != '0)   ld_cnt <= ld_cnt - LD_W'(1);
  end

  // A branch squashes only younger work; an in-flight mul keeps counting.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      mul_cnt <= '0;
      mul_rd  <= '0;
    end else if (mul_accept) begin
      mul_cnt <= MUL_INIT;
      mul_rd  <= IF_ID_rd;
    end else if (mul_cnt != '0) begin
      mul_cnt <= mul_cnt - MUL_W'(1);
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst)
      perf_q <= '0;
    else if (stall && !branch_taken && (perf_q != '1))
      perf_q <= perf_q + PERF_W'(1);
  end

  always_comb begin
    ctrl_out                 = ctrl_in;
    prevent_update_pc        = 1'b0;
    prevent_update_reg_IF_ID = 1'b0;
    flush_IF_ID              = 1'b0;
    mul_busy                 = (mul_cnt != '0);
    if (arst) begin
      ctrl_out = '0;
      mul_busy = 1'b0;
    end else if (branch_taken) begin
      ctrl_out    = '0;
      flush_IF_ID = 1'b1;
    end else if (stall) begin
      ctrl_out                 = '0;
      prevent_update_pc        = 1'b1;
      prevent_update_reg_IF_ID = 1'b1;
    end
  end

  assign stall_cycles = perf_q;

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench: dut_a (LOAD_LATENCY=1, PERF_W=2), dut_b (LOAD_LATENCY=3, PERF_W=16).
module tb_hazard_stall_unit;

  localparam logic [8:0] CTRL = 9'h1A5;

  logic       clk = 1'b0;
  logic       arst;
  logic [8:0] ctrl_in;
  logic [4:0] rs1, rs2, rd, ex_rd;
  logic       rs1_used, rs2_used, mul_issue, memread, branch_taken;

  logic [8:0]  ctrl_a, ctrl_b;
  logic        ppc_a, ppc_b, pif_a, pif_b, fl_a, fl_b, busy_a, busy_b;
  logic [1:0]  sc_a;
  logic [15:0] sc_b;

  always #5 clk = ~clk;

  hazard_stall_unit #(.LOAD_LATENCY(1), .MUL_LATENCY(4), .PERF_W(2)) dut_a (
    .clk(clk), .arst(arst), .ctrl_in(ctrl_in),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .IF_ID_rd(rd), .mul_issue(mul_issue), .memread_ID_EX(memread), .ID_EX_rd(ex_rd),
    .branch_taken(branch_taken), .ctrl_out(ctrl_a), .prevent_update_pc(ppc_a),
    .prevent_update_reg_IF_ID(pif_a), .flush_IF_ID(fl_a), .mul_busy(busy_a),
    .stall_cycles(sc_a));

  hazard_stall_unit #(.LOAD_LATENCY(3), .MUL_LATENCY(4), .PERF_W(16)) dut_b (
    .clk(clk), .arst(arst), .ctrl_in(ctrl_in),
    .IF_ID_rs1(rs1), .IF_ID_rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used),
    .IF_ID_rd(rd), .mul_issue(mul_issue), .memread_ID_EX(memread), .ID_EX_rd(ex_rd),
    .branch_taken(branch_taken), .ctrl_out(ctrl_b), .prevent_update_pc(ppc_b),
    .prevent_update_reg_IF_ID(pif_b), .flush_IF_ID(fl_b), .mul_busy(busy_b),
    .stall_cycles(sc_b));

  typedef struct packed {
    logic        sel;
    logic [8:0]  ctrl;
    logic        ppc, pif, flush, busy;
    logic [15:0] sc;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic drv(input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                     input logic u2, input logic mr, input logic [4:0] exr,
                     input logic mi, input logic [4:0] rdv, input logic br);
    rs1 = r1; rs1_used = u1; rs2 = r2; rs2_used = u2;
    memread = mr; ex_rd = exr; mul_issue = mi; rd = rdv; branch_taken = br;
  endtask

  // sel=0 -> dut_a, sel=1 -> dut_b; expectation queued, compared 1ns later
  task automatic chk(input logic sel, input string tag, input logic [8:0] c,
                     input logic p, input logic f, input logic bsy, input logic [15:0] sc);
    exp_t e, got;
    string t;
    exp_q.push_back('{sel: sel, ctrl: c, ppc: p, pif: p, flush: f, busy: bsy, sc: sc});
    tag_q.push_back(tag);
    #1;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (e.sel) got = '{sel: 1'b1, ctrl: ctrl_b, ppc: ppc_b, pif: pif_b, flush: fl_b, busy: busy_b, sc: sc_b};
    else       got = '{sel: 1'b0, ctrl: ctrl_a, ppc: ppc_a, pif: pif_a, flush: fl_a, busy: busy_a, sc: {14'd0, sc_a}};
    n_checks++;
    assert (got === e) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed ctrl=%h ppc=%b pif=%b flush=%b busy=%b sc=%0d expected ctrl=%h ppc=%b pif=%b flush=%b busy=%b sc=%0d",
             t, got.ctrl, got.ppc, got.pif, got.flush, got.busy, got.sc,
             e.ctrl, e.ppc, e.pif, e.flush, e.busy, e.sc);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    arst = 1'b1;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    arst = 1'b0;
  endtask

  initial begin
    arst = 1'b1;
    ctrl_in = CTRL;
    drv(5, 1, 0, 0, 1, 5, 0, 0, 0);
    @(negedge clk);
    chk(1, "reset_b", 9'h0, 0, 0, 0, 16'd0);
    chk(0, "reset_a", 9'h0, 0, 0, 0, 16'd0);

    // load-use, latency 1
    do_reset();
    chk(0, "ll1_idle", CTRL, 0, 0, 0, 16'd0);
    @(negedge clk); drv(5, 1, 0, 0, 1, 5, 0, 0, 0);
    chk(0, "ll1_stall", 9'h0, 1, 0, 0, 16'd0);
    @(negedge clk); drv(5, 1, 0, 0, 0, 5, 0, 0, 0);
    chk(0, "ll1_release", CTRL, 0, 0, 0, 16'd1);

    // load-use, latency 3
    do_reset();
    @(negedge clk); drv(5, 1, 0, 0, 1, 5, 0, 0, 0);
    chk(1, "ll3_c1", 9'h0, 1, 0, 0, 16'd0);
    @(negedge clk); drv(5, 1, 0, 0, 0, 5, 0, 0, 0);
    chk(1, "ll3_c2", 9'h0, 1, 0, 0, 16'd1);
    @(negedge clk);
    chk(1, "ll3_c3", 9'h0, 1, 0, 0, 16'd2);
    @(negedge clk);
    chk(1, "ll3_release", CTRL, 0, 0, 0, 16'd3);
    @(negedge clk); drv(0, 1, 0, 0, 1, 0, 0, 0, 0);
    chk(1, "ll3_x0", CTRL, 0, 0, 0, 16'd3);
    @(negedge clk); drv(1, 0, 5, 1, 1, 5, 0, 0, 0);
    chk(1, "ll3_rs2", 9'h0, 1, 0, 0, 16'd3);

    // multi-cycle RAW and structural hazards
    do_reset();
    @(negedge clk); drv(3, 0, 0, 0, 0, 0, 1, 7, 0);
    chk(1, "mul_accept", CTRL, 0, 0, 0, 16'd0);
    @(negedge clk); drv(7, 1, 0, 0, 0, 0, 0, 0, 0);
    chk(1, "mul_raw1", 9'h0, 1, 0, 1, 16'd0);
    for (int i = 1; i < 4; i++) begin
      @(negedge clk);
      chk(1, "mul_raw", 9'h0, 1, 0, 1, 16'(i));
    end
    @(negedge clk);
    chk(1, "mul_release", CTRL, 0, 0, 0, 16'd4);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 1, 9, 0);
    chk(1, "mul2_accept", CTRL, 0, 0, 0, 16'd4);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 1, 10, 0);
    chk(1, "mul_struct", 9'h0, 1, 0, 1, 16'd4);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk(1, "mul_indep", CTRL, 0, 0, 1, 16'd5);

    // branch during a latency-3 load stall with a mul in flight
    do_reset();
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 1, 7, 0);
    chk(1, "br_mul", CTRL, 0, 0, 0, 16'd0);
    @(negedge clk); drv(5, 1, 0, 0, 1, 5, 0, 0, 0);
    chk(1, "br_load", 9'h0, 1, 0, 1, 16'd0);
    @(negedge clk); drv(5, 1, 0, 0, 0, 5, 0, 0, 1);
    chk(1, "br_flush", 9'h0, 0, 1, 1, 16'd1);
    @(negedge clk); drv(5, 1, 0, 0, 0, 5, 0, 0, 0);
    chk(1, "br_after", CTRL, 0, 0, 1, 16'd1);

    // asynchronous reset mid-mul and mid-load
    do_reset();
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 1, 7, 0);
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); drv(5, 1, 0, 0, 1, 5, 0, 0, 0);
    chk(1, "rst_pre", 9'h0, 1, 0, 1, 16'd0);
    @(negedge clk); arst = 1'b1; drv(5, 1, 0, 0, 0, 5, 0, 0, 0);
    chk(1, "rst_mid", 9'h0, 0, 0, 0, 16'd0);
    @(negedge clk); arst = 1'b0; drv(7, 1, 0, 0, 0, 5, 0, 0, 0);
    chk(1, "rst_after", CTRL, 0, 0, 0, 16'd0);

    // saturating counter, PERF_W=2
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); drv(5, 1, 0, 0, 1, 5, 0, 0, 0);
      chk(0, "sat_hold", 9'h0, 1, 0, 0, 16'((i < 3) ? i : 3));
    end
    @(negedge clk); drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk(0, "sat_final", CTRL, 0, 0, 0, 16'd3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/hazard_stall_unit.md
Name: hazard_stall_unit

Overview:
Parametrised successor to the pipeline's load-use hazard logic. It sits between the main decoder and the ID/EX register and gates the decoded control bus into a bubble when a hazard is found. It covers four cases:
- load-use hazards with a configurable load latency;
- RAW and structural hazards against one in-flight multi-cycle (MUL/DIV) operation;
- branch/jump flush of the IF/ID stage;
- a saturating stall-cycle performance counter.

Parameters:
REG_ADDR_W, 5, register index width
CTRL_W, 9, width of the decoded control bus passed to ID/EX
LOAD_LATENCY, 1, stall cycles per load-use hazard (>=1)
MUL_LATENCY, 4, cycles a multi-cycle op occupies its unit (>=1)
PERF_W, 16, stall counter width

Ports:
clk  in  1  clock, rising edge
arst  in  1  asynchronous reset, active-high
ctrl_in  in  CTRL_W  decoded control bus from decoder
IF_ID_rs1  in  REG_ADDR_W  rs1 of instruction in ID
IF_ID_rs2  in  REG_ADDR_W  rs2 of instruction in ID
rs1_used  in  1  ID instruction reads rs1
rs2_used  in  1  ID instruction reads rs2
IF_ID_rd  in  REG_ADDR_W  rd of instruction in ID
mul_issue  in  1  ID instruction is a multi-cycle op
memread_ID_EX  in  1  instruction in EX is a load
ID_EX_rd  in  REG_ADDR_W  rd of instruction in EX
branch_taken  in  1  EX resolved a taken branch/jump
ctrl_out  out  CTRL_W  control bus to ID/EX; all-zero = bubble
prevent_update_pc  out  1  hold PC
prevent_update_reg_IF_ID  out  1  hold IF/ID
flush_IF_ID  out  1  squash IF/ID contents
mul_busy  out  1  multi-cycle unit occupied
stall_cycles  out  PERF_W  saturating count of stall cycles

Behaviour:
- State: ld_cnt (counts remaining extra load stalls), mul_cnt, mul_rd, stall_cycles. On arst all clear to 0 immediately. While arst is high, combinational outputs are forced as follows: ctrl_out=0, all stall/flush outputs=0, mul_busy=0.
- Register 0 never creates a hazard; compared rd equal to 0 means no match.
- load_hz (combinational) is true when ld_cnt==0 && memread_ID_EX && ID_EX_rd!=0 && ((rs1_used && IF_ID_rs1==ID_EX_rd) || (rs2_used && IF_ID_rs2==ID_EX_rd)).
- On load_hz, load ld_cnt with LOAD_LATENCY-1. While ld_cnt!=0, stall unconditionally and decrement ld_cnt by 1 per cycle. A load stall therefore lasts exactly LOAD_LATENCY cycles.
- mul_hz is true when mul_cnt!=0 && (mul_issue || (mul_rd!=0 && ((rs1_used && IF_ID_rs1==mul_rd) || (rs2_used && IF_ID_rs2==mul_rd)))).
- stall = load_hz || ld_cnt!=0 || mul_hz.
- Stall response in the same cycle: ctrl_out=0, prevent_update_pc=1, prevent_update_reg_IF_ID=1.
- No-stall response: ctrl_out=ctrl_in, both prevent outputs 0.
- Multi-cycle accept:
  - Acceptance requires mul_issue && !stall && !branch_taken.
  - On acceptance, at the clock edge: mul_cnt<=MUL_LATENCY, mul_rd<=IF_ID_rd.
  - Otherwise, if mul_cnt!=0, mul_cnt decrements by 1 per cycle.
  - mul_busy = (mul_cnt!=0).
  - The ID instruction may read mul_rd again starting in the cycle after mul_cnt reaches 0.
- Branch flush, branch_taken=1 (highest priority):
  - flush_IF_ID=1 and ctrl_out=0.
  - Both prevent outputs are forced to 0, so the PC loads the target.
  - ld_cnt clears to 0.
  - No mul is accepted that cycle.
  - An in-flight mul (older instruction) keeps counting; mul_cnt is not cleared.
- stall_cycles increments by 1 on each cycle with stall && !branch_taken. It saturates at all-ones and never wraps.
- Simultaneous load_hz and mul_hz produce a single stall. Both conditions are re-evaluated every cycle, so the stall ends only when both are clear.

Test Plan:
- Load-use, LOAD_LATENCY=1: memread_ID_EX=1, ID_EX_rd=5, IF_ID_rs1=5, rs1_used=1 -> one cycle with ctrl_out=0 and both prevent outputs=1; next cycle ctrl_out=ctrl_in; stall_cycles=1.
- LOAD_LATENCY=3, same stimulus (memread drops after the first cycle) -> stall exactly 3 cycles; stall_cycles=3. Rerun with ID_EX_rd=0 -> no stall.
- MUL_LATENCY=4: accept mul with IF_ID_rd=7, then ID reads x7 -> stall while mul_busy=1 (4 cycles); release the cycle after mul_cnt hits 0. A second mul_issue in that window also stalls.
- branch_taken=1 during the 2nd cycle of a LOAD_LATENCY=3 stall -> flush_IF_ID=1, prevents=0, ctrl_out=0; next cycle no stall (ld_cnt cleared). An in-flight mul_busy stays 1.
- arst asserted mid-mul (mul_cnt=2) and mid-load-stall -> outputs clear immediately; after deassert mul_busy=0, stall_cycles=0, no stall.
- PERF_W=2: hold a hazard for 6 cycles -> stall_cycles reads 1, 2, 3, 3, 3, 3 (saturates at 3, no wrap).
